// File: rtl/if_id_pipe_skid.sv
// IF/ID pipeline stage: valid/ready handshake with a one-entry skid buffer and flush.
// Optional stall-cycle counter on port stall_cnt, enabled by defining IF_ID_STALL_CNT_EN.
module if_id_pipe_skid #(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt
`endif
);

   // state | meaning
   // EMPTY | nothing held, out_valid low
   // FULL  | main register holds the beat shown on out_*
   // SKID  | main and skid both hold beats, in_ready low
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   state_t             state, state_nxt;
   logic               ld_main_in, ld_main_skid, ld_skid;
   logic [INSTR_W-1:0] main_instr, skid_instr;
   logic [PC_W-1:0]    main_pc, skid_pc;

   // in_ready depends only on the state register (and reset), never on out_ready
   assign in_ready  = reset_n & (state != SKID);
   assign out_valid = (state != EMPTY);
   assign out_instr = main_instr;
   assign out_pc    = main_pc;

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  ld_main_in = 1'b1;
                  state_nxt  = FULL;
               end
            end
            FULL: begin
               if (out_ready) begin
                  if (in_valid) ld_main_in = 1'b1;
                  else          state_nxt  = EMPTY;
               end else if (in_valid) begin
                  ld_skid   = 1'b1;
                  state_nxt = SKID;
               end
            end
            SKID: begin
               if (out_ready) begin
                  ld_main_skid = 1'b1;
                  state_nxt    = FULL;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // flush drops validity only; data registers keep their contents
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_instr <= '0;
         main_pc    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         if (ld_main_in) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
         end else if (ld_main_skid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
         end
         if (ld_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
         end
      end
   end

`ifdef IF_ID_STALL_CNT_EN
   // saturating count of cycles where decode holds off a valid beat; flush does not clear it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/if_id_pipe_skid.md
Name: if_id_pipe_skid

Overview:
Parametrised IF/ID pipeline stage for the RISC-V core. It replaces the fixed 32-bit stall-hold register with a valid/ready handshake stage and a one-entry skid buffer, so the fetch side never sees a combinational ready path from decode. It adds a flush input for branch/jump redirect and an optional stall-cycle counter. It sits between the fetch unit/I-cache (upstream) and the decode stage (downstream).

Parameters:
INSTR_W, 32, instruction word width
PC_W, 32, program-counter width
CNT_W, 16, stall counter width (used only when IF_ID_STALL_CNT_EN is defined)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  drop all held and incoming entries this cycle
in_valid  input  1  upstream has instr/PC
in_ready  output  1  stage can accept; registered
in_instr  input  INSTR_W  fetched instruction
in_pc  input  PC_W  PC of in_instr
out_valid  output  1  out_instr/out_pc valid
out_ready  input  1  decode accepts (drive as !busywait)
out_instr  output  INSTR_W  instruction to decode
out_pc  output  PC_W  PC to decode
stall_cnt  output  CNT_W  stall cycles (present only with IF_ID_STALL_CNT_EN)

Behaviour:
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Storage: main register (drives out_*), skid register, 3-state FSM: EMPTY, FULL (main valid), SKID (main and skid valid).
- in_ready = (state != SKID), taken from the FSM register only, with no combinational path from out_ready. in_ready is forced to 0 while reset_n is low.
- out_valid = (state != EMPTY). out_instr/out_pc = main register contents.
- Reset (async, reset_n low): state EMPTY, out_valid 0, main/skid data 0, stall_cnt 0.
- Transitions when flush = 0:
  - EMPTY: in_valid -> main <= in, FULL. Otherwise stay.
  - FULL, out_ready & in_valid: main <= in, stay FULL (full throughput, 1 transfer/cycle).
  - FULL, out_ready & !in_valid: EMPTY.
  - FULL, !out_ready & in_valid: skid <= in, SKID.
  - FULL, !out_ready & !in_valid: hold.
  - SKID, out_ready: main <= skid, FULL. Otherwise hold. in_valid is ignored because in_ready is 0.
- Flush has highest priority:
  - Next state EMPTY regardless of in_valid/out_ready. The incoming beat that cycle is discarded even though in_ready may be 1.
  - Data registers are not cleared; only validity is dropped.
- Latency: 1 cycle from input transfer to out_valid when the stage is EMPTY. Ordering is strictly FIFO and no entry is duplicated or lost except on flush.
- While out_valid & !out_ready, out_instr/out_pc are stable.
- Reset asserted mid-operation: immediate return to EMPTY with all valids 0. No state survives.

Optional Feature:
Macro IF_ID_STALL_CNT_EN.
- Defined: port stall_cnt exists.
  - Increments by 1 on each clk edge where out_valid & !out_ready (sampled pre-edge).
  - Saturates at all-ones.
  - Cleared only by reset_n, not by flush.
- Undefined: stall_cnt port and counter logic are absent. Handshake behaviour is identical in both builds.

Test Plan:
- Reset release, then in_valid=1, in_instr=0x00500093, in_pc=0x100, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_pc=0x100, in_ready=1.
- Stream 0x200, 0x204, 0x208 back-to-back with out_ready=1 -> appear on out_pc on consecutive cycles with no bubbles; in_ready stays 1.
- Load 0x300, then hold out_ready=0 while presenting 0x304 -> SKID: in_ready=0 next cycle, out_pc holds 0x300. Then out_ready=1 -> out_pc 0x300 then 0x304, in_ready returns 1.
- In SKID (0x400/0x404 held), flush=1 with in_valid=1 (0x408) -> next cycle out_valid=0, in_ready=1, and 0x400/0x404/0x408 never appear on out_*.
- reset_n driven low asynchronously mid-cycle while FULL -> out_valid=0 and out_instr=0 immediately, without waiting for clk; in_ready=0 until release.
- IF_ID_STALL_CNT_EN defined, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15. Flush -> still 15. Reset -> 0.
